// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock-divider bank.
package clk_div_pkg;
    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;
    localparam int   N_CH_DEF     = 4;
    localparam int   CNT_W_DEF    = 27;
endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, shadow (pending) divisor/mode, and
// registered output decode so o_clk/o_tick/o_busy never glitch.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_mode,
    input  logic             sync,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_busy
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] div_q, div_d, cnt_q, cnt_d, pdiv_q, pdiv_d;
    logic             mode_q, mode_d, pmode_q, pmode_d, pvld_q, pvld_d;
    logic             clk_q, clk_d, tick_q, tick_d, busy_q, busy_d;
    logic             running, wrap, synced;
    logic [CNT_W:0]   half;

    always_comb begin
        div_d   = div_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        pdiv_d  = pdiv_q;
        pmode_d = pmode_q;
        pvld_d  = pvld_q;
        synced  = 1'b0;
        running = (div_q != '0);
        wrap    = running && (cnt_q == div_q - ONE);

        // A write lands immediately whenever a new period starts this edge anyway.
        if (wr && (!running || sync || wrap)) begin
            div_d  = wr_div;
            mode_d = wr_mode;
            cnt_d  = '0;
            pvld_d = 1'b0;
        end else begin
            if (wr) begin
                pdiv_d  = wr_div;
                pmode_d = wr_mode;
                pvld_d  = 1'b1;
            end
            if (running && (sync || wrap)) begin
                cnt_d  = '0;
                synced = sync;
                if (pvld_q) begin
                    div_d  = pdiv_q;
                    mode_d = pmode_q;
                    pvld_d = 1'b0;
                end else if (wrap && (mode_q == MODE_ONESHOT)) begin
                    div_d = '0;
                end
            end else if (running) begin
                cnt_d = cnt_q + ONE;
            end
        end

        // Outputs are decoded from next state and registered alongside it.
        busy_d = (div_d != '0);
        half   = ({1'b0, div_d} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
        clk_d  = busy_d && ({1'b0, cnt_d} < half);
        tick_d = busy_d && (cnt_d == div_d - ONE) && !synced;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            pdiv_q  <= '0;
            pmode_q <= 1'b0;
            pvld_q  <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            pdiv_q  <= pdiv_d;
            pmode_q <= pmode_d;
            pvld_q  <= pvld_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
        end
    end

    assign o_clk  = clk_q;
    assign o_tick = tick_q;
    assign o_busy = busy_q;
endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers sharing one config port
// and a common phase-align strobe.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             fpga_clk,
    input  logic             reset,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_mode,
    input  logic             sync,
    output logic [N_CH-1:0]  o_clk,
    output logic [N_CH-1:0]  o_tick,
    output logic [N_CH-1:0]  o_busy,
    output logic             cfg_err
);
    logic [N_CH-1:0] wr_sel;
    logic            cfg_err_d, cfg_err_q;

    always_comb begin
        cfg_err_d = cfg_wr && (32'(cfg_ch) >= 32'(N_CH));
        wr_sel    = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_sel[i] = cfg_wr && (32'(cfg_ch) == 32'(i));
        end
    end

    always_ff @(posedge fpga_clk or negedge reset) begin
        if (!reset) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        clk_div_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk     (fpga_clk),
            .rst_n   (reset),
            .wr      (wr_sel[g]),
            .wr_div  (cfg_div),
            .wr_mode (cfg_mode),
            .sync    (sync),
            .o_clk   (o_clk[g]),
            .o_tick  (o_tick[g]),
            .o_busy  (o_busy[g])
        );
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed scenarios plus random traffic
// compared cycle by cycle against a period-countdown reference model.
module tb_clk_div_bank;
    import clk_div_pkg::*;

    localparam int N_CH  = 4;
    localparam int CNT_W = 27;
    localparam int CH_W  = 3;

    logic             fpga_clk;
    logic             reset;
    logic             cfg_wr;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_mode;
    logic             sync;
    logic [N_CH-1:0]  o_clk, o_tick, o_busy;
    logic             cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: active divisor, cycles left in the current period
    // (1 = last cycle), one-shot flag, pending write, post-sync marker.
    int m_div [N_CH];
    int m_left[N_CH];
    bit m_one [N_CH];
    int m_pdiv[N_CH];
    bit m_pone[N_CH];
    bit m_phas[N_CH];
    bit m_sync[N_CH];
    bit m_err;

    clk_div_bank #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W),
        .CH_W  (CH_W)
    ) dut (
        .fpga_clk (fpga_clk),
        .reset    (reset),
        .cfg_wr   (cfg_wr),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .sync     (sync),
        .o_clk    (o_clk),
        .o_tick   (o_tick),
        .o_busy   (o_busy),
        .cfg_err  (cfg_err)
    );

    initial begin
        fpga_clk = 1'b0;
        forever #5 fpga_clk = ~fpga_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_div[i] = 0; m_left[i] = 0; m_one[i] = 0;
            m_pdiv[i] = 0; m_pone[i] = 0; m_phas[i] = 0; m_sync[i] = 0;
        end
        m_err = 0;
    endtask

    task automatic model_load(input int i, input int d, input bit one);
        m_div[i]  = d;
        m_one[i]  = one;
        m_left[i] = d;
        m_phas[i] = 0;
    endtask

    task automatic model_edge(input bit wr, input int ch, input int d, input bit one, input bit sy);
        m_err = wr && (ch >= N_CH);
        for (int i = 0; i < N_CH; i++) begin
            bit hit, run, last;
            hit  = wr && (ch == i);
            run  = (m_div[i] != 0);
            last = run && (m_left[i] == 1);
            m_sync[i] = 0;
            if (hit && (!run || sy || last)) begin
                model_load(i, d, one);
            end else begin
                if (hit) begin
                    m_pdiv[i] = d; m_pone[i] = one; m_phas[i] = 1;
                end
                if (run && (sy || last)) begin
                    m_sync[i] = sy;
                    if (m_phas[i]) model_load(i, m_pdiv[i], m_pone[i]);
                    else if (last && m_one[i]) m_div[i] = 0;
                    else m_left[i] = m_div[i];
                end else if (run) begin
                    m_left[i] = m_left[i] - 1;
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [N_CH-1:0] e_clk, e_tick, e_busy;
        for (int i = 0; i < N_CH; i++) begin
            e_busy[i] = (m_div[i] != 0);
            e_tick[i] = (m_div[i] != 0) && (m_left[i] == 1) && !m_sync[i];
            e_clk[i]  = (m_div[i] != 0) && ((m_div[i] - m_left[i]) < (m_div[i] + 1) / 2);
        end
        check_eq("o_clk", 32'(o_clk), 32'(e_clk));
        check_eq("o_tick", 32'(o_tick), 32'(e_tick));
        check_eq("o_busy", 32'(o_busy), 32'(e_busy));
        check_eq("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    task automatic cycle(input bit wr, input int ch, input int d, input bit one, input bit sy);
        cfg_wr   = wr;
        cfg_ch   = CH_W'(ch);
        cfg_div  = CNT_W'(d);
        cfg_mode = one;
        sync     = sy;
        @(posedge fpga_clk);
        model_edge(wr, ch, d, one, sy);
        #1;
        compare_model();
        cfg_wr = 1'b0;
        sync   = 1'b0;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cfg_wr = 1'b0;
        sync   = 1'b0;
        reset  = 1'b0;
        @(posedge fpga_clk);
        #1;
        model_reset();
        check_eq("rst_clk", 32'(o_clk), 32'h0);
        check_eq("rst_tick", 32'(o_tick), 32'h0);
        check_eq("rst_busy", 32'(o_busy), 32'h0);
        check_eq("rst_err", 32'(cfg_err), 32'h0);
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b1;
        cfg_wr   = 1'b0;
        cfg_ch   = '0;
        cfg_div  = '0;
        cfg_mode = 1'b0;
        sync     = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Continuous D=4 on ch0: ticks at 4, 8, 12; high for first half.
        for (int c = 1; c <= 12; c++) begin
            if (c == 1) cycle(1, 0, 4, MODE_CONT, 0);
            else idle();
            check_eq("a_tick", 32'(o_tick[0]), 32'(c % 4 == 0));
            check_eq("a_clk", 32'(o_clk[0]), 32'((c - 1) % 4 < 2));
        end

        // Retune ch1 from 5 to 3 mid-period: old period completes first.
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            if (c == 1) cycle(1, 1, 5, MODE_CONT, 0);
            else if (c == 3) cycle(1, 1, 3, MODE_CONT, 0);
            else idle();
            check_eq("b_tick", 32'(o_tick[1]), 32'(c == 5 || c == 8 || c == 11 || c == 14));
        end

        // One-shot D=6 on ch2.
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            if (c == 1) cycle(1, 2, 6, MODE_ONESHOT, 0);
            else idle();
            check_eq("c_tick", 32'(o_tick[2]), 32'(c == 6));
            check_eq("c_busy", 32'(o_busy[2]), 32'(c <= 6));
        end

        // Phase-align ch0 (D=4) and ch1 (D=6); first common tick at 12.
        do_reset();
        cycle(1, 0, 4, MODE_CONT, 0);
        cycle(1, 1, 6, MODE_CONT, 0);
        idle();
        idle();
        for (int r = 1; r <= 12; r++) begin
            if (r == 1) cycle(0, 0, 0, 0, 1);
            else idle();
            check_eq("d_tick0", 32'(o_tick[0]), 32'(r % 4 == 0));
            check_eq("d_tick1", 32'(o_tick[1]), 32'(r % 6 == 0));
            check_eq("d_clk1", 32'(o_clk[1]), 32'((r - 1) % 6 < 3));
        end

        // Out-of-range channel write, then D=1 on ch3.
        do_reset();
        cycle(1, 0, 3, MODE_CONT, 0);
        idle();
        cycle(1, 5, 7, MODE_CONT, 0);
        check_eq("e_err", 32'(cfg_err), 32'h1);
        check_eq("e_busy", 32'(o_busy), 32'h1);
        idle();
        check_eq("e_err_clr", 32'(cfg_err), 32'h0);
        for (int c = 1; c <= 5; c++) begin
            if (c == 1) cycle(1, 3, 1, MODE_CONT, 0);
            else idle();
            check_eq("e_tick3", 32'(o_tick[3]), 32'h1);
            check_eq("e_clk3", 32'(o_clk[3]), 32'h1);
        end

        // Asynchronous reset in the middle of a period on every channel.
        do_reset();
        cycle(1, 0, 5, MODE_CONT, 0);
        cycle(1, 1, 7, MODE_CONT, 0);
        cycle(1, 2, 3, MODE_ONESHOT, 0);
        cycle(1, 3, 9, MODE_CONT, 0);
        idle();
        #3;
        reset = 1'b0;
        #1;
        check_eq("f_clk", 32'(o_clk), 32'h0);
        check_eq("f_tick", 32'(o_tick), 32'h0);
        check_eq("f_busy", 32'(o_busy), 32'h0);
        check_eq("f_err", 32'(cfg_err), 32'h0);
        model_reset();
        @(posedge fpga_clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            idle();
            check_eq("f_idle", 32'({o_clk, o_tick, o_busy}), 32'h0);
        end

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            cycle(($urandom_range(3) == 0), int'($urandom_range(5)), int'($urandom_range(9)),
                  ($urandom_range(3) == 0), ($urandom_range(15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent divider channels, legal range 1..16.
REQ-002 SHALL have parameter CNT_W, default 27: divisor and counter width, covering 100 MHz to 1 Hz.
REQ-003 SHALL have parameter CH_W, default $clog2(N_CH) (minimum 1): channel-select width.
REQ-004 SHALL have port fpga_clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port cfg_wr, input, 1 bit: one-cycle configuration write strobe.
REQ-007 SHALL have port cfg_ch, input, CH_W bits: target channel of a write.
REQ-008 SHALL have port cfg_div, input, CNT_W bits: divisor D; 0 = stop.
REQ-009 SHALL have port cfg_mode, input, 1 bit: 0 = continuous, 1 = one-shot.
REQ-010 SHALL have port sync, input, 1 bit: one-cycle phase-align strobe for all running channels.
REQ-011 SHALL have port o_clk, output, N_CH bits: per-channel divided square wave.
REQ-012 SHALL have port o_tick, output, N_CH bits: per-channel one-cycle period strobe.
REQ-013 SHALL have port o_busy, output, N_CH bits: channel running (active D != 0).
REQ-014 SHALL have port cfg_err, output, 1 bit: one-cycle pulse on a write with cfg_ch >= N_CH.

Function
REQ-015 SHALL keep per channel: active divisor D, mode, counter cnt, pending divisor/mode, and a pending-valid flag.
REQ-016 SHALL, for a running channel, count cnt 0..D-1 and wrap to 0; wrap occurs on the edge after cnt == D-1.
REQ-017 SHALL assert o_tick[i] exactly in cycles where the channel is running and cnt == D-1.
REQ-018 SHALL drive o_clk[i] high while cnt < ceil(D/2), low otherwise; D=1 gives constant high and o_tick every cycle.
REQ-019 SHALL make o_clk, o_tick and o_busy glitch-free, decoded only from registered state.
REQ-020 SHALL, on a write to an idle channel (D == 0), load D and mode immediately, with cnt = 0 in the next cycle, so that the first o_tick follows D cycles after the write edge.
REQ-021 SHALL, on a write to a running channel, store the value as pending and apply it at the next wrap; cnt restarts at 0 with the new D.
REQ-022 SHALL let a second write before that wrap overwrite the pending value (last write wins).
REQ-023 SHALL, on a pending D = 0, stop the channel at the wrap: o_busy, o_clk and o_tick go 0 and cnt is held at 0.
REQ-024 SHALL, in one-shot mode, clear D to 0 at the wrap following the first o_tick, unless a pending value exists; in that case the pending value is applied instead.
REQ-025 SHALL, on sync, apply any pending values, then force cnt = 0 on every channel whose resulting D != 0; o_tick is suppressed in the sync cycle.
REQ-026 SHALL give cfg_wr priority over sync when both hit the same channel in the same cycle: the written value is loaded immediately and cnt = 0.
REQ-027 SHALL, for a write with cfg_ch >= N_CH, change no state and pulse cfg_err in the next cycle.

Reset
REQ-028 SHALL, while reset = 0 (asynchronous, active-low), clear all D, cnt, pending, mode and flags, and drive o_clk = 0, o_tick = 0, o_busy = 0 and cfg_err = 0.
REQ-029 SHALL have reset mid-period abort all channels with no tick, and remain idle after release until written.

Structure
REQ-030 SHALL place in package clk_div_pkg: the MODE_CONT/MODE_ONESHOT constants and the default N_CH/CNT_W values.
REQ-031 SHALL implement one sub-module, clk_div_chan (counter, shadow register, output decode), instantiated N_CH times via generate.
REQ-032 SHALL keep the write decode, sync fan-out and cfg_err logic in the top level.

Verification
REQ-033 SHALL cover: write ch0 D=4 continuous at edge 0 -> cnt 0..3 in cycles 1..4; o_tick in cycles 4, 8, 12; o_clk high in cycles 1-2, low in 3-4.
REQ-034 SHALL cover: ch1 running D=5, write D=3 at cnt=1 -> current period completes at 5, then period 3; no shortened or doubled tick.
REQ-035 SHALL cover: ch2 one-shot D=6 -> exactly one o_tick, 6 cycles after the write; o_busy drops at the following edge.
REQ-036 SHALL cover: ch0 D=4 and ch1 D=6 running, sync pulse -> both cnt = 0 next cycle, coincident o_tick at cycle 12 after sync (the least common multiple).
REQ-037 SHALL cover: write cfg_ch=5 with N_CH=4 -> cfg_err pulse, all outputs unchanged; write D=1 -> o_tick every cycle, o_clk constant 1.
REQ-038 SHALL cover: reset asserted mid-period on all channels -> outputs 0 asynchronously; after release, no activity until a new write.
